// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, and the counter-width helper.
package alu_pkg;

   typedef logic [2:0] opcode_t;

   localparam opcode_t OP_PASSA = 3'b000;
   localparam opcode_t OP_SUB   = 3'b001;
   localparam opcode_t OP_ADD   = 3'b010;
   localparam opcode_t OP_AND   = 3'b011;
   localparam opcode_t OP_XOR   = 3'b100;
   localparam opcode_t OP_PASSB = 3'b101;
   localparam opcode_t OP_OR    = 3'b110;
   localparam opcode_t OP_MUL   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Bits needed to count 0..v-1; never less than one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bus between a requester and the multi-cycle ALU.
interface alu_mc_if
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   opcode_t          opcode;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic             carry_out;
   logic             a_is_zero;
   logic             result_zero;

   modport slave (
      input  in_valid, opcode, in_a, in_b, out_ready,
      output in_ready, out_valid, alu_out, carry_out, a_is_zero, result_zero
   );

   modport master (
      output in_valid, opcode, in_a, in_b, out_ready,
      input  in_ready, out_valid, alu_out, carry_out, a_is_zero, result_zero
   );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle datapath for every opcode except MUL; carry holds the add carry or the sub borrow.
module alu_comb
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  opcode_t          op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_c_o,
   output logic             carry_c_o
);

   logic [WIDTH:0] sum_c;
   logic [WIDTH:0] diff_c;

   assign sum_c  = {1'b0, a_i} + {1'b0, b_i};
   // Borrow lands in the extra top bit exactly when a < b.
   assign diff_c = {1'b0, a_i} - {1'b0, b_i};

   always_comb begin
      result_c_o = '0;
      carry_c_o  = 1'b0;
      case (op_i)
         OP_PASSA: result_c_o = a_i;
         OP_SUB: begin
            result_c_o = diff_c[WIDTH-1:0];
            carry_c_o  = diff_c[WIDTH];
         end
         OP_ADD: begin
            result_c_o = sum_c[WIDTH-1:0];
            carry_c_o  = sum_c[WIDTH];
         end
         OP_AND:   result_c_o = a_i & b_i;
         OP_XOR:   result_c_o = a_i ^ b_i;
         OP_PASSB: result_c_o = b_i;
         OP_OR:    result_c_o = a_i | b_i;
         default: begin
            result_c_o = '0;
            carry_c_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops complete in one cycle, MUL runs a WIDTH-step shift-add loop.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   alu_mc_if.slave  bus
);

   localparam int unsigned CNT_W = clog2(WIDTH);
   localparam int unsigned PW    = 2 * WIDTH;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [PW-1:0]    acc_q;
   logic [PW-1:0]    mcand_q;
   logic [WIDTH-1:0] mplier_q;

   logic             out_valid_q;
   logic [WIDTH-1:0] alu_out_q;
   logic             carry_q;
   logic             a_zero_q;
   logic             res_zero_q;

   logic             in_ready_c;
   logic             accept_c;
   logic [PW-1:0]    acc_d;
   logic [WIDTH-1:0] comb_res_c;
   logic             comb_carry_c;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .op_i       (bus.opcode),
      .a_i        (bus.in_a),
      .b_i        (bus.in_b),
      .result_c_o (comb_res_c),
      .carry_c_o  (comb_carry_c)
   );

   // Ready in IDLE, or in DONE when the held result is being drained this cycle.
   assign in_ready_c = !rst && ((state_q == S_IDLE) ||
                                ((state_q == S_DONE) && bus.out_ready));
   assign accept_c   = bus.in_valid && in_ready_c;

   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         out_valid_q <= 1'b0;
         alu_out_q   <= '0;
         carry_q     <= 1'b0;
         a_zero_q    <= 1'b0;
         res_zero_q  <= 1'b0;
      end else begin
         case (state_q)
            S_BUSY: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q     <= S_DONE;
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
                  alu_out_q   <= acc_d[WIDTH-1:0];
                  carry_q     <= |acc_d[PW-1:WIDTH];
                  res_zero_q  <= (acc_d[WIDTH-1:0] == '0);
               end
            end
            default: begin
               if (accept_c) begin
                  a_zero_q <= (bus.in_a == '0);
                  if (bus.opcode == OP_MUL) begin
                     state_q     <= S_BUSY;
                     out_valid_q <= 1'b0;
                     cnt_q       <= '0;
                     acc_q       <= '0;
                     mcand_q     <= PW'(bus.in_a);
                     mplier_q    <= bus.in_b;
                  end else begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     alu_out_q   <= comb_res_c;
                     carry_q     <= comb_carry_c;
                     res_zero_q  <= (comb_res_c == '0);
                  end
               end else if ((state_q == S_IDLE) || bus.out_ready) begin
                  // Result drained with nothing new arriving (or already idle).
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.alu_out     = alu_out_q;
   assign bus.carry_out   = carry_q;
   assign bus.a_is_zero   = a_zero_q;
   assign bus.result_zero = res_zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=8 with directed vectors and hand-computed results.
module tb_alu_mc;
   import alu_pkg::*;

   logic clk;
   logic rst;

   alu_mc_if #(.WIDTH(8)) bus ();

   alu_mc #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] out;
      logic       c;
      logic       az;
      logic       rz;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   waits;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Present a request and hold it until accepted; expectation is queued at acceptance.
   task automatic issue(input opcode_t op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eo, input logic ec, input logic eaz, input logic erz,
                        input bit push, output int w);
      exp_t x;
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.in_a     = a;
      bus.in_b     = b;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 40) begin
         w++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: op %0d never accepted", op);
      end else if (push) begin
         x.out = eo; x.c = ec; x.az = eaz; x.rz = erz;
         exp_q.push_back(x);
      end
      @(posedge clk); #1;
   endtask

   task automatic drop();
      bus.in_valid = 1'b0;
   endtask

   // Monitor: every result taken by the consumer is compared against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", bus.alu_out);
            end else begin
               e = exp_q.pop_front();
               chk("sb_alu_out",     32'(bus.alu_out),     32'(e.out));
               chk("sb_carry_out",   32'(bus.carry_out),   32'(e.c));
               chk("sb_a_is_zero",   32'(bus.a_is_zero),   32'(e.az));
               chk("sb_result_zero", 32'(bus.result_zero), 32'(e.rz));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.opcode    = OP_PASSA;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",    32'(bus.in_ready),    32'd0);
      chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
      chk("rst_alu_out",     32'(bus.alu_out),     32'd0);
      chk("rst_carry",       32'(bus.carry_out),   32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;

      // ADD with carry, one-cycle latency
      issue(OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, waits);
      drop();
      @(negedge clk);
      chk("add_latency_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;

      // SUB with borrow, then SUB to zero
      issue(OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, waits);
      issue(OP_SUB, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, waits);
      issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, waits);
      issue(OP_ADD, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, waits);
      issue(OP_PASSA, 8'hCA, 8'h33, 8'hCA, 1'b0, 1'b0, 1'b0, 1'b1, waits);
      drop();
      repeat (2) @(posedge clk); #1;

      // MUL latency: 8 busy cycles, result in the ninth
      issue(OP_MUL, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, waits);
      drop();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("mul_busy_in_ready",  32'(bus.in_ready),  32'd0);
         chk("mul_busy_out_valid", 32'(bus.out_valid), 32'd0);
      end
      @(negedge clk);
      chk("mul_done_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;

      // MUL with a zero operand still takes full latency
      issue(OP_MUL, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, waits);
      drop();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("mul0_busy_out_valid", 32'(bus.out_valid), 32'd0);
      end
      @(negedge clk);
      chk("mul0_done_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;

      // Back-to-back single-cycle ops, one per cycle
      issue(OP_AND,   8'hCA, 8'h5C, 8'h48, 1'b0, 1'b0, 1'b0, 1'b1, waits);
      chk("b2b_and_wait", 32'(waits), 32'd0);
      issue(OP_XOR,   8'hCA, 8'h5C, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, waits);
      chk("b2b_xor_wait", 32'(waits), 32'd0);
      issue(OP_PASSB, 8'hCA, 8'h5C, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b1, waits);
      chk("b2b_passb_wait", 32'(waits), 32'd0);
      issue(OP_OR,    8'hCA, 8'h5C, 8'hDE, 1'b0, 1'b0, 1'b0, 1'b1, waits);
      chk("b2b_or_wait", 32'(waits), 32'd0);
      drop();
      repeat (2) @(posedge clk); #1;

      // Consumer stall: result held, next request waits, accepted on release
      bus.out_ready = 1'b0;
      issue(OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1, waits);
      bus.in_valid = 1'b1;
      bus.opcode   = OP_XOR;
      bus.in_a     = 8'hFF;
      bus.in_b     = 8'h0F;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_alu_out",   32'(bus.alu_out),   32'h46);
         chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      issue(OP_XOR, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, waits);
      chk("release_accept_wait", 32'(waits), 32'd0);
      drop();
      repeat (2) @(posedge clk); #1;

      // Reset during MUL step 4 aborts it with no output
      issue(OP_MUL, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, waits);
      drop();
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_out_valid",   32'(bus.out_valid),   32'd0);
      chk("abort_alu_out",     32'(bus.alu_out),     32'd0);
      chk("abort_carry",       32'(bus.carry_out),   32'd0);
      chk("abort_a_is_zero",   32'(bus.a_is_zero),   32'd0);
      chk("abort_result_zero", 32'(bus.result_zero), 32'd0);
      chk("abort_in_ready",    32'(bus.in_ready),    32'd1);
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_output", 32'(bus.out_valid), 32'd0);
      end
      @(posedge clk); #1;
      issue(OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, waits);
      drop();

      // Drain scoreboard
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL flag that opcode/in_a/in_b carry a request.
REQ-005 in_ready  output  1  SHALL flag that the block accepts a request this cycle.
REQ-006 opcode  input  3  SHALL select the operation.
REQ-007 in_a  input  WIDTH  SHALL carry operand A.
REQ-008 in_b  input  WIDTH  SHALL carry operand B.
REQ-009 out_valid  output  1  SHALL flag that the result outputs hold a valid result.
REQ-010 out_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-011 alu_out  output  WIDTH  SHALL carry the registered result.
REQ-012 carry_out  output  1  SHALL carry the registered carry, borrow or overflow flag.
REQ-013 a_is_zero  output  1  SHALL be registered, and high when the captured in_a was 0.
REQ-014 result_zero  output  1  SHALL be registered, and high when alu_out is 0.

Function
REQ-015 A request SHALL be accepted on a cycle where in_valid and in_ready are both high; operands and opcode are captured at that edge.
REQ-016 Opcodes: 000 PASSA, 001 SUB, 010 ADD, 011 AND, 100 XOR, 101 PASSB, 110 OR, 111 MUL.
REQ-017 ADD SHALL produce alu_out=(a+b) mod 2^WIDTH, with carry_out=bit WIDTH of the full sum.
REQ-018 SUB SHALL produce alu_out=(a-b) mod 2^WIDTH, with carry_out=1 iff a<b (unsigned borrow).
REQ-019 AND, OR, XOR, PASSA and PASSB SHALL be bitwise or pass-through operations, with carry_out=0.
REQ-020 MUL SHALL be unsigned and iterative, using one shift-add step per cycle for WIDTH cycles; alu_out=low WIDTH bits of the product, carry_out=OR of the high WIDTH bits.
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-022 IDLE: on accept of a non-MUL request, go to DONE with the result registered; on accept of MUL, go to BUSY with the step counter = 0.
REQ-023 BUSY: increment the counter each cycle; after step WIDTH-1 completes, go to DONE.
REQ-024 DONE: out_valid=1 and all result outputs held stable until out_ready=1, then leave DONE.
REQ-025 Latency from accept to out_valid SHALL be 1 cycle for non-MUL ops and WIDTH+1 cycles for MUL.
REQ-026 in_ready SHALL be 1 in IDLE, 1 in DONE while out_ready=1, and 0 in BUSY.
REQ-027 DONE with out_ready=1 and a simultaneous accept SHALL go directly to the new request's next state, with no bubble: back-to-back non-MUL throughput is 1 per cycle.
REQ-028 DONE with out_ready=1 and no accept SHALL go to IDLE with out_valid=0.
REQ-029 in_valid, opcode and operands SHALL be ignored while in_ready=0.
REQ-030 MUL with in_a=0 or in_b=0 SHALL still take the full WIDTH+1 latency.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, counter=0, out_valid=0, alu_out=0, carry_out=0, a_is_zero=0, result_zero=0.
REQ-032 rst SHALL take priority over every other input, including mid-MUL (BUSY) and in DONE; the aborted operation produces no output.
REQ-033 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.

Structure
REQ-034 Package alu_pkg SHALL hold the opcode localparams, the FSM state encoding and the counter-width function clog2.
REQ-035 The single-cycle datapath (all ops except MUL) SHALL be a combinational sub-module alu_comb, parameterised by WIDTH, returning result and carry.
REQ-036 The MUL accumulator, the multiplicand shift register and the counter SHALL reside in alu_mc.

Verification
REQ-037 WIDTH=8, ADD a=0xF0 b=0x20 -> one cycle later: out_valid=1, alu_out=0x10, carry_out=1, result_zero=0, a_is_zero=0.
REQ-038 SUB a=0x03 b=0x05 -> alu_out=0xFE, carry_out=1; then SUB a=0x05 b=0x05 -> alu_out=0x00, result_zero=1, carry_out=0.
REQ-039 MUL a=0x10 b=0x11 -> in_ready=0 for 8 cycles, out_valid on cycle 9, alu_out=0x10, carry_out=1; MUL a=0 b=0x7F -> out_valid on cycle 9, alu_out=0, a_is_zero=1.
REQ-040 Back-to-back AND/XOR/PASSB/OR with in_valid and out_ready held at 1 -> one result per cycle, in order, correct values.
REQ-041 out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs held stable, in_ready=0, no request lost; release -> the next request is accepted on that cycle.
REQ-042 rst pulsed at MUL step 4 -> next cycle: IDLE, out_valid=0, all outputs 0; a following ADD 1+1 -> alu_out=0x02.
